// File: rtl/simon_pkg.sv
// simon_pkg: shared state encoding, width defaults and Simon-32/64 known-answer
// vectors for the SIMON host controller.
package simon_pkg;

    localparam int N_DEF = 16;
    localparam int M_DEF = 4;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_KEY_REQ  = 3'd1;
    localparam state_t S_KEY_WAIT = 3'd2;
    localparam state_t S_DAT_REQ  = 3'd3;
    localparam state_t S_DAT_WAIT = 3'd4;
    localparam state_t S_READ     = 3'd5;
    localparam state_t S_OUT_HOLD = 3'd6;

    localparam logic [63:0] TV_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] TV_PT  = 32'h6565_6877;
    localparam logic [31:0] TV_CT  = 32'hc69b_e9bb;

    // States in which the host is waiting on the core and the watchdog runs.
    function automatic logic is_wait(input state_t s);
        return s inside {S_KEY_REQ, S_KEY_WAIT, S_DAT_REQ, S_DAT_WAIT};
    endfunction

endpackage

// File: rtl/simon_watchdog.sv
// simon_watchdog: saturating per-state wait counter; expired fires on the cycle
// whose edge would bring the count to TMO.
module simon_watchdog #(
    parameter int TMO = 255
) (
    input  logic clk,
    input  logic nR,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TMO + 1);

    logic [CW-1:0] count;

    assign expired = enable && (count >= CW'(TMO - 1));

    always_ff @(posedge clk or negedge nR) begin
        if (!nR)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != CW'(TMO))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/simon_3264_host.sv
// simon_3264_host: stream-side host that loads keys and blocks into a SIMON
// core through its request/done handshake and returns results on a stream.
module simon_3264_host
    import simon_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int M   = M_DEF,
    parameter int TMO = 255
) (
    input  logic             clk,
    input  logic             nR,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [M*N-1:0]   key_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_data,
    output logic             newKey,
    output logic             newData,
    output logic             readData,
    output logic             enc_dec,
    output logic [M*N-1:0]   KEY,
    output logic [2*N-1:0]   blockIN,
    input  logic             loadKey,
    input  logic             loadData,
    input  logic             doneKey,
    input  logic             doneData,
    input  logic [2*N-1:0]   outData,
    output logic             key_loaded,
    output logic             err
);

    state_t state, state_nx;
    logic   key_acc, blk_acc, tmo;

    // Key wins over a simultaneous block offer.
    assign in_ready = key_ready && key_loaded && !key_valid;
    assign key_acc  = key_valid && key_ready;
    assign blk_acc  = in_valid && in_ready;

    simon_watchdog #(.TMO(TMO)) u_wdog (
        .clk     (clk),
        .nR      (nR),
        .clear   (state_nx != state),
        .enable  (is_wait(state)),
        .expired (tmo)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     state_nx = key_acc ? S_KEY_REQ : blk_acc ? S_DAT_REQ : S_IDLE;
            S_KEY_REQ:  state_nx = loadKey ? S_KEY_WAIT : S_KEY_REQ;
            S_KEY_WAIT: state_nx = doneKey ? S_IDLE : S_KEY_WAIT;
            S_DAT_REQ:  state_nx = loadData ? S_DAT_WAIT : S_DAT_REQ;
            S_DAT_WAIT: state_nx = doneData ? S_READ : S_DAT_WAIT;
            S_READ:     state_nx = S_OUT_HOLD;
            S_OUT_HOLD: state_nx = out_ready ? S_IDLE : S_OUT_HOLD;
            default:    state_nx = S_IDLE;
        endcase
        if (tmo)
            state_nx = S_IDLE;
    end

    // Control outputs are registered decodes of the next state so they never glitch.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state      <= S_IDLE;
            key_ready  <= 1'b0;
            newKey     <= 1'b0;
            newData    <= 1'b0;
            readData   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            enc_dec    <= 1'b0;
            KEY        <= '0;
            blockIN    <= '0;
            key_loaded <= 1'b0;
            err        <= 1'b0;
        end else begin
            state     <= state_nx;
            key_ready <= state_nx == S_IDLE;
            newKey    <= state_nx == S_KEY_REQ;
            newData   <= state_nx == S_DAT_REQ;
            readData  <= state_nx == S_READ;
            out_valid <= state_nx == S_OUT_HOLD;
            if (key_acc) begin
                KEY        <= key_in;
                key_loaded <= 1'b0;
                err        <= 1'b0;
            end else if (state == S_KEY_WAIT && doneKey) begin
                key_loaded <= 1'b1;
            end
            if (blk_acc) begin
                blockIN <= in_data;
                enc_dec <= in_mode;
            end
            if (state == S_READ)
                out_data <= outData;
            if (tmo) begin
                err        <= 1'b1;
                key_loaded <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simon_3264_host.sv
// tb_simon_3264_host: drives the host against a behavioural Simon-32/64 core and
// checks results, handshakes, watchdog and reset behaviour.
module tb_simon_3264_host;
    import simon_pkg::*;

    logic        clk = 1'b0, nR = 1'b0;
    logic        key_valid = 1'b0, in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
    logic [63:0] key_in = '0;
    logic [31:0] in_data = '0;
    logic        key_ready, in_ready, out_valid, newKey, newData, readData, enc_dec;
    logic        key_loaded, err;
    logic [31:0] out_data, blockIN;
    logic [63:0] KEY;
    logic        loadKey = 1'b0, loadData = 1'b0, doneKey = 1'b0, doneData = 1'b0;
    logic [31:0] outData = '0;

    int n_cmp = 0, n_err = 0;
    int rd_cnt = 0, nk_cnt = 0, ov_cnt = 0;
    logic nk_prev = 1'b0;
    int ld_dly = 1, dn_dly = 3;
    logic stall = 1'b0;
    int kst = 0, kc = 0, dst = 0, dc = 0;
    logic [63:0] ck = '0;

    simon_3264_host #(.N(16), .M(4), .TMO(8)) dut (
        .clk(clk), .nR(nR),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .newKey(newKey), .newData(newData), .readData(readData), .enc_dec(enc_dec),
        .KEY(KEY), .blockIN(blockIN),
        .loadKey(loadKey), .loadData(loadData), .doneKey(doneKey), .doneData(doneData),
        .outData(outData), .key_loaded(key_loaded), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rotl(input logic [15:0] x, input int s);
        return (x << s) | (x >> (16 - s));
    endfunction

    function automatic logic [15:0] rf(input logic [15:0] x);
        return (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2);
    endfunction

    // Simon-32/64 straight from the published round and key-schedule equations.
    function automatic logic [31:0] simon(input logic [63:0] key, input logic [31:0] blk, input logic enc);
        logic [15:0] k [32];
        logic [15:0] x, y, t;
        logic [61:0] z;
        z = 62'b11111010_00100101_01100001_11001101_11110100_01001010_11000011_100110;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = rotl(k[i-1], 13) ^ k[i-3];
            t = t ^ rotl(t, 15);
            k[i] = ~k[i-4] ^ t ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
        end
        x = blk[31:16];
        y = blk[15:0];
        if (enc) begin
            for (int i = 0; i < 32; i++) begin t = x; x = y ^ rf(x) ^ k[i]; y = t; end
        end else begin
            for (int i = 31; i >= 0; i--) begin t = y; y = x ^ rf(t) ^ k[i]; x = t; end
        end
        return {x, y};
    endfunction

    // Behavioural core: load after ld_dly cycles, done after dn_dly more.
    always @(negedge clk) begin
        if (!nR) begin
            loadKey = 0; doneKey = 0; loadData = 0; doneData = 0;
            kst = 0; dst = 0;
        end else begin
            if (kst == 0) begin
                if (newKey) begin ck = KEY; kc = 0; kst = 1; end
            end else if (kst == 1) begin
                if (!newKey) kst = 0;
                else begin kc++; if (kc >= ld_dly) begin loadKey = 1; kst = 2; end end
            end else if (kst == 2) begin
                loadKey = 0; kc = 0; kst = 3;
            end else if (kst == 3) begin
                kc++; if (kc >= dn_dly) begin doneKey = 1; kst = 4; end
            end else begin
                doneKey = 0; kst = 0;
            end
            if (dst == 0) begin
                if (newData) begin dc = 0; dst = 1; end
            end else if (dst == 1) begin
                if (!newData) dst = 0;
                else begin dc++; if (dc >= ld_dly && !stall) begin loadData = 1; dst = 2; end end
            end else if (dst == 2) begin
                loadData = 0; dc = 0; dst = 3;
            end else if (dst == 3) begin
                dc++;
                if (dc >= dn_dly) begin doneData = 1; outData = simon(ck, blockIN, enc_dec); dst = 4; end
            end else begin
                doneData = 0; dst = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (readData) rd_cnt++;
        if (newKey && !nk_prev) nk_cnt++;
        nk_prev = newKey;
        if (out_valid) ov_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load_key(input logic [63:0] k);
        logic a;
        a = 1'b0;
        key_in = k;
        key_valid = 1'b1;
        for (int i = 0; i < 200 && !a; i++) begin a = key_ready; tick; end
        key_valid = 1'b0;
        chk("key_accept", a, 1);
        for (int i = 0; i < 200 && !key_loaded; i++) tick;
        chk("key_loaded", key_loaded, 1);
    endtask

    task automatic send_block(input logic [31:0] d, input logic m, input int hold, output logic [31:0] res);
        logic a, stable;
        a = 1'b0;
        in_data = d;
        in_mode = m;
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 200 && !a; i++) begin a = in_ready; tick; end
        in_valid = 1'b0;
        chk("blk_accept", a, 1);
        for (int i = 0; i < 200 && !out_valid; i++) tick;
        chk("out_valid_seen", out_valid, 1);
        res = out_data;
        stable = 1'b1;
        if (hold > 0) begin
            in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick;
                if (!(out_valid === 1'b1 && out_data === res && in_ready === 1'b0)) stable = 1'b0;
            end
            in_valid = 1'b0;
            chk("hold_stable", stable, 1);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("out_drop", out_valid, 0);
    endtask

    typedef struct {
        logic [63:0] key;
        logic [31:0] blk;
        logic        mode;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [8];
    logic [63:0] cur_key, rk;
    logic [31:0] res;
    logic        bad;
    int          rd0, nk0, ov0;
    logic        a;

    initial begin
        vecs[0] = '{TV_KEY, TV_PT, 1'b1, TV_CT};
        vecs[1] = '{TV_KEY, TV_CT, 1'b0, TV_PT};
        rk = TV_KEY;
        for (int i = 2; i < 8; i++) begin
            if (i % 2 == 0) rk = {$urandom, $urandom};
            vecs[i].key  = rk;
            vecs[i].blk  = $urandom;
            vecs[i].mode = $urandom_range(0, 1);
            vecs[i].exp  = simon(vecs[i].key, vecs[i].blk, vecs[i].mode);
        end

        tick; tick;
        chk("rst_handshake", {key_ready, in_ready, out_valid}, 0);
        chk("rst_core_ctl", {newKey, newData, readData, enc_dec}, 0);
        chk("rst_status", {key_loaded, err}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_operands", KEY | {32'd0, blockIN}, 0);
        nR = 1'b1;
        tick;
        chk("idle_key_ready", key_ready, 1);
        chk("idle_no_key_in_ready", in_ready, 0);

        in_data = TV_PT;
        in_mode = 1'b1;
        in_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin tick; if (in_ready !== 1'b0) bad = 1'b1; end
        chk("no_key_block_stall", bad, 0);
        load_key(TV_KEY);
        cur_key = TV_KEY;
        rd0 = rd_cnt;
        send_block(TV_PT, 1'b1, 0, res);
        chk("first_enc", res, TV_CT);
        chk("first_rd_pulse", rd_cnt - rd0, 1);

        key_valid = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("key_wins", in_ready, 0);
        key_valid = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            nk0 = nk_cnt;
            rd0 = rd_cnt;
            a = (vecs[i].key != cur_key);
            if (a) begin load_key(vecs[i].key); cur_key = vecs[i].key; end
            send_block(vecs[i].blk, vecs[i].mode, 0, res);
            chk($sformatf("vec%0d_out", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_newkey", i), nk_cnt - nk0, a ? 1 : 0);
            chk($sformatf("vec%0d_rd_pulse", i), rd_cnt - rd0, 1);
        end

        load_key(TV_KEY);
        send_block(TV_PT, 1'b1, 10, res);
        chk("hold_result", res, TV_CT);

        stall = 1'b1;
        in_data = $urandom;
        in_valid = 1'b1;
        a = 1'b0;
        for (int i = 0; i < 200 && !a; i++) begin a = in_ready; tick; end
        in_valid = 1'b0;
        chk("wdog_accept", a, 1);
        chk("wdog_dreq_entry", newData, 1);
        repeat (7) tick;
        chk("wdog_not_yet", {err, newData}, 2'b01);
        tick;
        chk("wdog_err", err, 1);
        chk("wdog_key_lost", key_loaded, 0);
        chk("wdog_ctl_off", {newData, newKey, readData, out_valid}, 0);
        chk("wdog_idle", key_ready, 1);
        stall = 1'b0;
        tick;
        load_key(TV_KEY);
        chk("err_cleared", err, 0);

        dn_dly = 5;
        ov0 = ov_cnt;
        in_data = TV_PT;
        in_mode = 1'b1;
        in_valid = 1'b1;
        a = 1'b0;
        for (int i = 0; i < 200 && !a; i++) begin a = in_ready; tick; end
        in_valid = 1'b0;
        for (int i = 0; i < 50 && dst != 3; i++) tick;
        chk("in_dat_wait", {newData, readData, out_valid, key_ready}, 0);
        nR = 1'b0;
        #1;
        chk("arst_ctl", {out_valid, newKey, newData, readData, key_ready, in_ready, enc_dec}, 0);
        chk("arst_status", {key_loaded, err}, 0);
        chk("arst_data", {out_data, blockIN}, 0);
        chk("arst_key", KEY, 0);
        tick; tick;
        nR = 1'b1;
        repeat (20) tick;
        chk("arst_no_out", ov_cnt - ov0, 0);
        chk("arst_key_gone", key_loaded, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/simon_3264_host.md
SIMON_3264_HOST -- requirements
Module: simon_3264_host

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning cipher word width in bits.
REQ-002 The block SHALL have parameter M, default 4, meaning key words.
REQ-003 The block SHALL have parameter TMO, default 255, meaning watchdog limit in cycles per core wait.
REQ-004 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port nR  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port key_valid / key_ready  input / output  1 / 1  key stream handshake.
REQ-007 The block SHALL have port key_in  input  M*N  key, word M-1 in the MSBs.
REQ-008 The block SHALL have port in_valid / in_ready  input / output  1 / 1  block stream handshake.
REQ-009 The block SHALL have port in_data  input  2*N  block.
REQ-010 The block SHALL have port in_mode  input  1  1 = encrypt, 0 = decrypt.
REQ-011 The block SHALL have port out_valid / out_ready  output / input  1 / 1  result stream handshake.
REQ-012 The block SHALL have port out_data  output  2*N  result.
REQ-013 The block SHALL have port newKey, newData, readData, enc_dec  output  1 each  core controls.
REQ-014 The block SHALL have port KEY / blockIN  output  M*N / 2*N  core operands.
REQ-015 The block SHALL have port loadKey, loadData, doneKey, doneData  input  1 each  core status.
REQ-016 The block SHALL have port outData  input  2*N  core result.
REQ-017 The block SHALL have port key_loaded / err  output  1 / 1  valid schedule present / sticky watchdog error.

Function
REQ-018 Stream transfers SHALL occur only on cycles where valid and ready are both high.
REQ-019 The block SHALL sequence the FSM states IDLE, KEY_REQ, KEY_WAIT, DAT_REQ, DAT_WAIT, READ and OUT_HOLD.
REQ-020 IDLE SHALL raise key_ready; it SHALL also raise in_ready only when key_loaded=1.
REQ-021 When key_valid and in_valid are both high in IDLE, the key SHALL win and in_ready SHALL be low that cycle.
REQ-022 A key accept SHALL register key_in to KEY, clear key_loaded and move to KEY_REQ.
REQ-023 KEY_REQ SHALL hold newKey=1 with KEY stable until loadKey=1, then drop newKey next cycle and move to KEY_WAIT.
REQ-024 KEY_WAIT SHALL, on doneKey=1, set key_loaded and return to IDLE.
REQ-025 A block accept SHALL register in_data to blockIN and in_mode to enc_dec, then move to DAT_REQ.
REQ-026 DAT_REQ SHALL hold newData=1 until loadData=1, then move to DAT_WAIT.
REQ-027 DAT_WAIT SHALL, on doneData=1, move to READ.
REQ-028 READ SHALL pulse readData for exactly one cycle, capture outData into out_data that cycle and move to OUT_HOLD.
REQ-029 OUT_HOLD SHALL keep out_valid=1 and out_data stable until out_ready=1, then return to IDLE.
REQ-030 Single-block latency from block accept to out_valid SHALL be core latency plus 3 cycles.
REQ-031 A watchdog counter SHALL clear on every state entry and increment in KEY_REQ, KEY_WAIT, DAT_REQ and DAT_WAIT.
REQ-032 When the watchdog counter reaches TMO, the block SHALL set err, clear key_loaded, deassert all core controls and go to IDLE.
REQ-033 The watchdog counter SHALL saturate and never wrap.
REQ-034 err SHALL clear only on reset or on the next accepted key.
REQ-035 key_valid and in_valid SHALL be ignored outside IDLE.
REQ-036 enc_dec, KEY and blockIN SHALL hold their last value outside a request.

Reset
REQ-037 nR low SHALL asynchronously force IDLE, zero all outputs, registers and counter, and clear key_loaded and err.
REQ-038 Reset mid-operation SHALL discard any in-flight block without emitting out_valid.
REQ-039 Outputs SHALL be glitch-free after nR deasserts.

Structure
REQ-040 A shared package simon_pkg SHALL hold the FSM state enum, N/M defaults, and the 32/64 test-vector constants.
REQ-041 The watchdog SHALL be a sub-module simon_watchdog with inputs clear and enable, parameter TMO, and output expired.
REQ-042 The whole design SHALL be 200-300 lines of RTL.

Verification
REQ-043 Bench SHALL cover: key 1918_1110_0908_0100 then block 6565_6877 with in_mode=1, against the real core -> out_data=c69b_e9bb, readData high for exactly 1 cycle.
REQ-044 Bench SHALL cover: same key, block c69b_e9bb with in_mode=0 -> out_data=6565_6877, with no second newKey issued.
REQ-045 Bench SHALL cover: in_valid=1 before any key -> in_ready=0 indefinitely; after key load completes -> block accepted.
REQ-046 Bench SHALL cover: out_ready held low for 10 cycles -> out_valid and out_data stable, in_ready=0 throughout.
REQ-047 Bench SHALL cover: core model never asserts loadData, with TMO=8 -> err=1 and key_loaded=0 at cycle 8 after DAT_REQ entry, newData=0, state IDLE.
REQ-048 Bench SHALL cover: nR pulsed low during DAT_WAIT -> all outputs 0 immediately; out_valid never asserted for that block.
